// File: rtl/ifu_fetch_if.sv
// Fetch-stage bus: instruction-memory request/response channels and the
// instruction handshake towards decode/execute.
interface ifu_fetch_if #(
    parameter int ISA_WIDTH = 32
);
    // Handshakes: a request transfers on the cycle both imem_req_valid and
    // imem_req_ready are high; valid and addr stay stable until then. The
    // response is valid-only (no backpressure). An instruction retires on the
    // cycle both inst_valid and inst_ready are high.
    logic                 imem_req_valid;
    logic                 imem_req_ready;
    logic [ISA_WIDTH-1:0] imem_req_addr;
    logic                 imem_rsp_valid;
    logic [ISA_WIDTH-1:0] imem_rsp_data;
    logic                 imem_rsp_err;
    logic                 inst_valid;
    logic                 inst_ready;
    logic [ISA_WIDTH-1:0] inst;
    logic [ISA_WIDTH-1:0] inst_pc;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid, imem_rsp_data, imem_rsp_err,
        output inst_valid, inst, inst_pc,
        input  inst_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid, imem_rsp_data, imem_rsp_err,
        input  inst_valid, inst, inst_pc,
        output inst_ready
    );
endinterface

// File: rtl/ifu_fetch.sv
// Instruction fetch stage: owns the PC, fetches one instruction at a time and
// halts on fetch fault, misaligned PC or non-writing retirement. Optional
// performance counters are enabled by the IFU_PERF_EN macro.
module ifu_fetch #(
    parameter int                   ISA_WIDTH = 32,
    parameter logic [ISA_WIDTH-1:0] RESET_PC  = 32'h8000_0000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ISA_WIDTH-1:0] pc_in,
    input  logic                 pc_w_en,
    output logic [ISA_WIDTH-1:0] pc_out,
    output logic                 halted,
    output logic                 fetch_fault,
    output logic [2:0]           state_dbg,
`ifdef IFU_PERF_EN
    output logic [31:0]          perf_fetch_cnt,
    output logic [31:0]          perf_stall_cnt,
`endif
    ifu_fetch_if.master          bus
);

    localparam logic [2:0] S_BOOT = 3'd0;
    localparam logic [2:0] S_REQ  = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_OUT  = 3'd3;
    localparam logic [2:0] S_HALT = 3'd4;

    logic [2:0]           state;
    logic [ISA_WIDTH-1:0] pc;
    logic [ISA_WIDTH-1:0] inst_q;
    logic                 fault_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_BOOT;
            pc      <= RESET_PC;
            inst_q  <= '0;
            fault_q <= 1'b0;
        end else begin
            case (state)
                S_BOOT: state <= S_REQ;
                S_REQ: begin
                    if (bus.imem_req_ready) state <= S_WAIT;
                end
                S_WAIT: begin
                    if (bus.imem_rsp_valid) begin
                        if (bus.imem_rsp_err) begin
                            fault_q <= 1'b1;
                            state   <= S_HALT;
                        end else begin
                            inst_q <= bus.imem_rsp_data;
                            state  <= S_OUT;
                        end
                    end
                end
                S_OUT: begin
                    // pc_w_en is only meaningful on the retiring cycle
                    if (bus.inst_ready) begin
                        if (!pc_w_en) begin
                            state <= S_HALT;
                        end else if (pc_in[1:0] == 2'b00) begin
                            pc    <= pc_in;
                            state <= S_REQ;
                        end else begin
                            fault_q <= 1'b1;
                            state   <= S_HALT;
                        end
                    end
                end
                S_HALT: state <= S_HALT;
                default: state <= S_HALT;
            endcase
        end
    end

`ifdef IFU_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetch_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (state == S_WAIT && bus.imem_rsp_valid && !bus.imem_rsp_err)
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if (state == S_REQ || state == S_WAIT)
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

    // All outputs decode registered state only; no memory-input paths.
    assign bus.imem_req_valid = (state == S_REQ);
    assign bus.imem_req_addr  = pc;
    assign bus.inst_valid     = (state == S_OUT);
    assign bus.inst           = inst_q;
    assign bus.inst_pc        = pc;
    assign pc_out             = pc;
    assign halted             = (state == S_HALT);
    assign fetch_fault        = fault_q;
    assign state_dbg          = state;

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: boot, stalls, backpressure, faults, halts and
// mid-transaction reset with a stale response.
module tb_ifu_fetch;

    logic        clk;
    logic        rst;
    logic [31:0] pc_in;
    logic        pc_w_en;
    logic [31:0] pc_out;
    logic        halted;
    logic        fetch_fault;
    logic [2:0]  state_dbg;
`ifdef IFU_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    ifu_fetch_if #(.ISA_WIDTH(32)) bus ();

    ifu_fetch #(.ISA_WIDTH(32), .RESET_PC(32'h8000_0000)) dut (
        .clk            (clk),
        .rst            (rst),
        .pc_in          (pc_in),
        .pc_w_en        (pc_w_en),
        .pc_out         (pc_out),
        .halted         (halted),
        .fetch_fault    (fetch_fault),
        .state_dbg      (state_dbg),
`ifdef IFU_PERF_EN
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt),
`endif
        .bus            (bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // drivers
    task automatic do_reset();
        rst = 1'b1;
        #1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic mem_accept(input int stall, input logic [31:0] addr);
        bus.imem_req_ready = 1'b0;
        for (int i = 0; i < stall; i++) begin
            tick();
            check("stall_req_valid", {31'd0, bus.imem_req_valid}, 32'd1);
            check("stall_req_addr", bus.imem_req_addr, addr);
        end
        bus.imem_req_ready = 1'b1;
        tick();
        bus.imem_req_ready = 1'b0;
    endtask

    task automatic mem_respond(input logic [31:0] data, input logic err);
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = data;
        bus.imem_rsp_err   = err;
        tick();
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_err   = 1'b0;
    endtask

    task automatic retire(input logic wen, input logic [31:0] npc);
        bus.inst_ready = 1'b1;
        pc_w_en        = wen;
        pc_in          = npc;
        tick();
        bus.inst_ready = 1'b0;
        pc_w_en        = 1'b0;
    endtask

    initial begin
        rst                = 1'b1;
        pc_in              = '0;
        pc_w_en            = 1'b0;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        bus.imem_rsp_err   = 1'b0;
        bus.inst_ready     = 1'b0;
        tick();
        tick();

        // reset values
        check("rst_state", {29'd0, state_dbg}, 32'd0);
        check("rst_pc", pc_out, 32'h8000_0000);
        check("rst_req_valid", {31'd0, bus.imem_req_valid}, 32'd0);
        check("rst_inst_valid", {31'd0, bus.inst_valid}, 32'd0);
        check("rst_inst", bus.inst, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        check("rst_fault", {31'd0, fetch_fault}, 32'd0);

        // boot and zero-wait fetch
        rst = 1'b0;
        tick();
        check("boot_req_valid", {31'd0, bus.imem_req_valid}, 32'd1);
        check("boot_req_addr", bus.imem_req_addr, 32'h8000_0000);
        mem_accept(0, 32'h8000_0000);
        check("wait_req_valid", {31'd0, bus.imem_req_valid}, 32'd0);
        mem_respond(32'h0000_0413, 1'b0);
        check("t1_inst_valid", {31'd0, bus.inst_valid}, 32'd1);
        check("t1_inst", bus.inst, 32'h0000_0413);
        check("t1_inst_pc", bus.inst_pc, 32'h8000_0000);
        check("t1_halted", {31'd0, halted}, 32'd0);
`ifdef IFU_PERF_EN
        check("t1_perf_fetch", perf_fetch_cnt, 32'd1);
        check("t1_perf_stall", perf_stall_cnt, 32'd2);
`endif

        // retire to next PC, memory ready stalled 3 cycles
        retire(1'b1, 32'h8000_0004);
        check("t2_pc", pc_out, 32'h8000_0004);
        check("t2_req_valid", {31'd0, bus.imem_req_valid}, 32'd1);
        check("t2_inst_valid", {31'd0, bus.inst_valid}, 32'd0);
        mem_accept(3, 32'h8000_0004);
        mem_respond(32'h0010_0093, 1'b0);
        check("t2_inst", bus.inst, 32'h0010_0093);
        check("t2_inst_pc", bus.inst_pc, 32'h8000_0004);
`ifdef IFU_PERF_EN
        check("t2_perf_fetch", perf_fetch_cnt, 32'd2);
        check("t2_perf_stall", perf_stall_cnt, 32'd7);
`endif

        // downstream backpressure while pc_in toggles
        for (int i = 0; i < 5; i++) begin
            pc_w_en = 1'b1;
            pc_in   = (i % 2 == 0) ? 32'h8000_0008 : 32'h8000_0003;
            tick();
            check("t3_inst_valid", {31'd0, bus.inst_valid}, 32'd1);
            check("t3_inst", bus.inst, 32'h0010_0093);
            check("t3_pc", pc_out, 32'h8000_0004);
        end
        retire(1'b1, 32'h8000_0100);
        check("t3_pc_new", pc_out, 32'h8000_0100);

        // fetch error
        mem_accept(0, 32'h8000_0100);
        mem_respond(32'h1234_5678, 1'b1);
        check("t4_halted", {31'd0, halted}, 32'd1);
        check("t4_fault", {31'd0, fetch_fault}, 32'd1);
        check("t4_inst_valid", {31'd0, bus.inst_valid}, 32'd0);
        bus.imem_req_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            bus.imem_rsp_valid = (i % 3 == 0);
            tick();
            check("t4_no_req", {31'd0, bus.imem_req_valid}, 32'd0);
        end
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        check("t4_pc_frozen", pc_out, 32'h8000_0100);
        check("t4_still_halted", {31'd0, halted}, 32'd1);

        // clean halt on pc_w_en=0
        do_reset();
        mem_accept(0, 32'h8000_0000);
        mem_respond(32'h0010_0073, 1'b0);
        check("t5a_inst", bus.inst, 32'h0010_0073);
        retire(1'b0, 32'h8000_0004);
        check("t5a_halted", {31'd0, halted}, 32'd1);
        check("t5a_fault", {31'd0, fetch_fault}, 32'd0);
        check("t5a_pc", pc_out, 32'h8000_0000);
        check("t5a_inst_valid", {31'd0, bus.inst_valid}, 32'd0);

        // misaligned next PC
        do_reset();
        check("t5b_fault_cleared", {31'd0, fetch_fault}, 32'd0);
        mem_accept(0, 32'h8000_0000);
        mem_respond(32'h0000_0013, 1'b0);
        retire(1'b1, 32'h8000_0006);
        check("t5b_halted", {31'd0, halted}, 32'd1);
        check("t5b_fault", {31'd0, fetch_fault}, 32'd1);
        check("t5b_pc", pc_out, 32'h8000_0000);

        // reset in S_WAIT, then a stale response
        do_reset();
        retire(1'b1, 32'h8000_0000);
        mem_accept(0, 32'h8000_0000);
        mem_respond(32'h0000_0093, 1'b0);
        retire(1'b1, 32'h8000_0040);
        mem_accept(0, 32'h8000_0040);
        check("t6_in_wait", {29'd0, state_dbg}, 32'd2);
        rst = 1'b1;
        #1;
        check("t6_async_state", {29'd0, state_dbg}, 32'd0);
        check("t6_async_pc", pc_out, 32'h8000_0000);
        check("t6_async_inst", bus.inst, 32'd0);
        check("t6_async_req", {31'd0, bus.imem_req_valid}, 32'd0);
`ifdef IFU_PERF_EN
        check("t6_perf_fetch_rst", perf_fetch_cnt, 32'd0);
        check("t6_perf_stall_rst", perf_stall_cnt, 32'd0);
`endif
        tick();
        rst                = 1'b0;
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = 32'hDEAD_BEEF;
        tick();
        tick();
        bus.imem_rsp_valid = 1'b0;
        check("t6_stale_state", {29'd0, state_dbg}, 32'd1);
        check("t6_stale_inst", bus.inst, 32'd0);
        check("t6_stale_inst_valid", {31'd0, bus.inst_valid}, 32'd0);
        check("t6_fresh_req", {31'd0, bus.imem_req_valid}, 32'd1);
        check("t6_fresh_addr", bus.imem_req_addr, 32'h8000_0000);
        mem_accept(0, 32'h8000_0000);
        mem_respond(32'h0000_0513, 1'b0);
        check("t6_inst", bus.inst, 32'h0000_0513);
        check("t6_inst_pc", bus.inst_pc, 32'h8000_0000);
`ifdef IFU_PERF_EN
        check("t6_perf_fetch", perf_fetch_cnt, 32'd1);
        check("t6_perf_stall", perf_stall_cnt, 32'd3);
`endif

        // report
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
